// File: rtl/serial_ling_subtractor.sv
// Multi-precision subtractor: diff = a - b computed one 16-bit limb per clock,
// LSB limb first, on a single 16-bit sparse-2 Ling adder (a + ~b + carry).
// A registered carry links the limbs; borrow/zero/ovf are registered with the
// final limb and held together with diff while out_valid is high.
module serial_ling_subtractor #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             ovf
);

  localparam int NLIMB = WIDTH / 16;
  localparam int IDXW  = (NLIMB > 1) ? $clog2(NLIMB) : 1;

  if ((WIDTH % 16) != 0 || WIDTH < 16) begin : g_bad_width
    $error("serial_ling_subtractor: WIDTH must be a positive multiple of 16");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // 16-bit sparse-2 Ling adder. Ling pseudo-carries H are formed only at odd
  // bit positions (H[2j+1] = g[2j+1] | c[2j]); real carries are recovered as
  // c[2j+1] = t[2j+1] & H[2j+1], and the even carries locally from them.
  function automatic logic [16:0] ling16(input logic [15:0] x,
                                         input logic [15:0] y,
                                         input logic        cin);
    logic [15:0] g, t, p, sum;
    logic [16:0] tx;
    logic [7:0]  gpx, pr, h;
    logic [3:0]  g4, p4;
    logic        hin, cprev, ceven;
    g  = x & y;
    t  = x | y;
    p  = x ^ y;
    // t shifted up one place; bit 0 stands for t[-1], taken as 1 so that the
    // incoming carry can be injected as H[-1] = cin.
    tx = {t, 1'b1};
    for (int j = 0; j < 8; j++) begin
      gpx[j] = g[2*j+1] | g[2*j];
      pr[j]  = tx[2*j+1] & tx[2*j];
    end
    for (int k = 0; k < 4; k++) begin
      g4[k] = gpx[2*k+1] | (pr[2*k+1] & gpx[2*k]);
      p4[k] = pr[2*k+1] & pr[2*k];
    end
    hin = cin;
    for (int k = 0; k < 4; k++) begin
      h[2*k]   = gpx[2*k] | (pr[2*k] & hin);
      h[2*k+1] = g4[k]    | (p4[k]   & hin);
      hin      = h[2*k+1];
    end
    cprev = cin;
    for (int j = 0; j < 8; j++) begin
      ceven      = g[2*j] | (t[2*j] & cprev);
      sum[2*j]   = p[2*j] ^ cprev;
      sum[2*j+1] = p[2*j+1] ^ ceven;
      cprev      = t[2*j+1] & h[j];
    end
    return {cprev, sum};
  endfunction

  state_t            state, state_nx;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [IDXW-1:0]   idx;
  logic              carry;
  logic              zacc;
  logic [15:0]       a_limb, b_limb, s;
  logic              c16;
  logic              last;

  assign a_limb       = a_q[16*idx +: 16];
  assign b_limb       = b_q[16*idx +: 16];
  assign {c16, s}     = ling16(a_limb, ~b_limb, carry);
  assign last         = (idx == IDXW'(NLIMB - 1));

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  // NOTE: state_nx gets a default before the case so no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid && in_ready) state_nx = RUN;
      RUN:     if (last)                 state_nx = DONE;
      DONE:    if (out_ready)            state_nx = IDLE;
      default:                           state_nx = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Operand latch, limb datapath and result flags.
  // NOTE: a_q/b_q are not reset; they are always reloaded before being read.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      carry  <= 1'b1;
      zacc   <= 1'b1;
      diff   <= '0;
      borrow <= 1'b0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q   <= a;
            b_q   <= b;
            idx   <= '0;
            carry <= 1'b1;
            zacc  <= 1'b1;
          end
        end
        RUN: begin
          diff[16*idx +: 16] <= s;
          carry              <= c16;
          zacc               <= zacc & (s == 16'h0000);
          idx                <= idx + 1'b1;
          if (last) begin
            idx    <= '0;
            borrow <= ~c16;
            zero   <= zacc & (s == 16'h0000);
            // Operands of differing sign and a result whose sign differs from a.
            ovf    <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (s[15] ^ a_q[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
